bcd_serial_addsub: RTL and testbench

Digit-serial, multi-digit packed-BCD adder/subtractor with a start/done handshake. It processes one BCD digit per clock from the least-significant digit upward and applies the standard +6 decimal correction to each digit. It is the parametrised successor to the team's single-digit combinational BCD adder and serves datapaths that need wide decimal arithmetic (counters, display math, decimal accumulators) without a long combinational carry chain.

---
 rtl/bcd_serial_addsub.sv | 128 ++++++++++++
 tb/tb_bcd_serial_addsub.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with +6 correction per digit and a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; result/cout/invalid hold the last completed operation
// RUN   | processing digit cnt_q of the latched operands
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, work_q, work_nxt;
  logic            sub_q, carry_q, inv_q;
  logic            carry_nxt, inv_in;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      a_dig, b_dig, bd, dig;
  logic [4:0]      s;
  logic            accept, last;

  assign busy   = (state == RUN);
  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt_q == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Subtract uses the nines' complement of b with the borrow folded into carry.
  always_comb begin
    bd = sub_q ? (4'd9 - b_dig) : b_dig;
    s  = {1'b0, a_dig} + {1'b0, bd} + {4'b0, carry_q};
    if (s > 5'd9) begin
      dig       = s[3:0] + 4'd6;
      carry_nxt = 1'b1;
    end else begin
      dig       = s[3:0];
      carry_nxt = 1'b0;
    end
    work_nxt = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) work_nxt[4*i +: 4] = dig;
    end
  end

  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) inv_in = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= sub;
        carry_q <= sub ? ~cin : cin;
        inv_q   <= inv_in;
        cnt_q   <= '0;
      end else if (busy) begin
        work_q  <= work_nxt;
        carry_q <= carry_nxt;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          result  <= work_nxt;
          cout    <= carry_nxt;
          invalid <= inv_q;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: 4-digit vector table, handshake corner cases,
// and an exhaustive single-digit sweep against a decimal reference.
module tb_bcd_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, cout4, invalid4;
  logic [15:0] result4;
  logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, cout1, invalid1;
  logic [3:0]  result1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .invalid(invalid4)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .cin(cin1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .invalid(invalid1)
  );

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        co;
    logic        inv;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Launch one 4-digit op, scramble inputs while running, return start->done latency.
  task automatic op4(input logic s, input logic c, input logic [15:0] aa, input logic [15:0] bb,
                     output int lat, output int bcnt);
    @(negedge clk);
    start4 = 1'b1; sub4 = s; cin4 = c; a4 = aa; b4 = bb;
    @(posedge clk); #1;
    bcnt = busy4 ? 1 : 0;
    @(negedge clk);
    start4 = 1'b0; sub4 = ~s; cin4 = ~c; a4 = 16'h9999; b4 = 16'h9999;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy4) bcnt++;
    end while (!done4 && lat < 12);
  endtask

  task automatic op1(input logic s, input logic c, input logic [3:0] aa, input logic [3:0] bb,
                     output int lat);
    @(negedge clk);
    start1 = 1'b1; sub1 = s; cin1 = c; a1 = aa; b1 = bb;
    @(posedge clk); #1;
    @(negedge clk);
    start1 = 1'b0; sub1 = ~s; a1 = 4'h0; b1 = 4'h0;
    lat = 0;
    while (!done1 && lat < 8) begin
      lat++;
      if (lat > 1) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int lat, bcnt, nd, d_first, d_second, t, eres, eco;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h8766, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0999, 16'h0001, 16'h1001, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h9999, 16'h9999, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h9999, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h9999, 16'h9999, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'h12A4, 16'h0001, 16'h1305, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0};

    #12;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_result", result4, 0);
    check("rst_cout", cout4, 0);
    check("rst_invalid", invalid4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      op4(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
      check($sformatf("vec%0d_result", i), result4, vecs[i].res);
      check($sformatf("vec%0d_cout", i), cout4, vecs[i].co);
      check($sformatf("vec%0d_invalid", i), invalid4, vecs[i].inv);
    end

    // start pulsed during RUN must be ignored
    @(negedge clk);
    start4 = 1'b1; sub4 = 1'b0; cin4 = 1'b0; a4 = 16'h1234; b4 = 16'h8766;
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    @(posedge clk);
    @(negedge clk); start4 = 1'b1; a4 = 16'h1111; b4 = 16'h1111;
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    nd = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done4) nd++;
    end
    check("run_start_done_count", nd, 1);
    check("run_start_result", result4, 16'h0000);
    check("run_start_cout", cout4, 1);

    // start held high: accepted at E0, ignored in RUN, re-accepted in the done cycle
    @(negedge clk);
    start4 = 1'b1; sub4 = 1'b0; cin4 = 1'b0; a4 = 16'h0001; b4 = 16'h0001;
    nd = 0; d_first = -1; d_second = -1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done4) begin
        nd++;
        if (d_first < 0) d_first = e;
        else if (d_second < 0) d_second = e;
      end
      if (done4 && busy4) check("done_with_busy", 1, 0);
    end
    @(negedge clk); start4 = 1'b0;
    check("held_done_count", nd, 2);
    check("held_first_done_edge", d_first, 4);
    check("held_second_done_edge", d_second, 9);
    check("held_result", result4, 16'h0002);
    repeat (6) @(posedge clk);

    // reset in the middle of RUN
    op4(1'b0, 1'b0, 16'h0100, 16'h0200, lat, bcnt);
    check("pre_rst_result", result4, 16'h0300);
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h4444; b4 = 16'h4444;
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy4, 0);
    check("midrst_done", done4, 0);
    check("midrst_result", result4, 0);
    check("midrst_cout", cout4, 0);
    check("midrst_invalid", invalid4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      if (done4 || busy4) nd++;
    end
    check("midrst_no_done", nd, 0);
    op4(1'b1, 1'b0, 16'h5000, 16'h1234, lat, bcnt);
    check("post_rst_latency", lat, 4);
    check("post_rst_result", result4, 16'h3766);
    check("post_rst_cout", cout4, 1);

    // single-digit instance
    op1(1'b0, 1'b1, 4'h9, 4'h9, lat);
    check("d1_latency", lat, 1);
    check("d1_result", result1, 4'h9);
    check("d1_cout", cout1, 1);
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int ai = 0; ai < 10; ai++) begin
          for (int bi = 0; bi < 10; bi++) begin
            if (s == 0) begin
              t = ai + bi + c;
              eco = (t >= 10) ? 1 : 0;
              eres = t % 10;
            end else begin
              t = ai - bi - c;
              eco = (t >= 0) ? 1 : 0;
              eres = (t < 0) ? t + 10 : t;
            end
            op1(s[0], c[0], ai[3:0], bi[3:0], lat);
            check($sformatf("sweep_s%0d_c%0d_a%0d_b%0d", s, c, ai, bi),
                  {27'd0, invalid1, cout1, result1}, {27'd0, 1'b0, eco[0], eres[3:0]});
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
